// File: rtl/timers_t1_sfr_bank_if.sv
// rtl/timers_t1_sfr_bank_if.sv - CPU SFR bus bundle for the Timer 1 SFR bank
interface timers_t1_sfr_bank_if;
  logic [7:0] sfr_addr_i;
  logic       sfr_wr_i;
  logic       sfr_rd_i;
  logic [7:0] sfr_wdata_i;
  logic [7:0] sfr_rdata_o;
  logic       sfr_rvalid_o;

  modport master (
    output sfr_addr_i, sfr_wr_i, sfr_rd_i, sfr_wdata_i,
    input  sfr_rdata_o, sfr_rvalid_o
  );

  modport slave (
    input  sfr_addr_i, sfr_wr_i, sfr_rd_i, sfr_wdata_i,
    output sfr_rdata_o, sfr_rvalid_o
  );
endinterface

// File: rtl/timers_t1_sfr_bank.sv
// rtl/timers_t1_sfr_bank.sv - Timer 1 count/TCON/TMOD SFR bank with atomic access and TF1 interrupt
module timers_t1_sfr_bank #(
  parameter logic [7:0] ADDR_TCON = 8'h88,
  parameter logic [7:0] ADDR_TMOD = 8'h89,
  parameter logic [7:0] ADDR_TL1  = 8'h8B,
  parameter logic [7:0] ADDR_TH1  = 8'h8D,
  parameter logic [7:0] ADDR_TM1  = 8'h8E
) (
  input  logic                        timers_clock_i,
  input  logic                        timers_reset_i_b,
  timers_t1_sfr_bank_if.slave         sfr,
  input  logic [7:0]                  tmr_th1_i,
  input  logic [7:0]                  tmr_tm1_i,
  input  logic [7:0]                  tmr_tl1_i,
  input  logic                        tmr_tf1_i,
  output logic [7:0]                  sfr_th1_o,
  output logic [7:0]                  sfr_tm1_o,
  output logic [7:0]                  sfr_tl1_o,
  output logic                        sfr_tf1_o,
  output logic                        sfr_tr1_o,
  output logic                        sfr_gate_t1_o,
  output logic                        sfr_m1t1_o,
  output logic                        sfr_m0t1_o,
  input  logic                        int_en_t1_i,
  input  logic                        int_ack_t1_i,
  output logic                        int_req_t1_o
);

  logic [7:0] th1_q, tm1_q, tl1_q, th1_d, tm1_d, tl1_d;
  logic [7:0] stg_th1_q, stg_tm1_q, stg_th1_d, stg_tm1_d;
  logic       pend_th1_q, pend_tm1_q, pend_th1_d, pend_tm1_d;
  logic [15:0] snap_q, snap_d;
  logic       snap_vld_q, snap_vld_d;
  logic       tf1_q, tr1_q, tf1_d, tr1_d;
  logic [5:0] tcon_lo_q, tcon_lo_d;
  logic [3:0] tmod_q, tmod_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;

  logic wr_tcon, wr_tmod, wr_tl1, wr_th1, wr_tm1;

  assign wr_tcon = sfr.sfr_wr_i && (sfr.sfr_addr_i == ADDR_TCON);
  assign wr_tmod = sfr.sfr_wr_i && (sfr.sfr_addr_i == ADDR_TMOD);
  assign wr_tl1  = sfr.sfr_wr_i && (sfr.sfr_addr_i == ADDR_TL1);
  assign wr_th1  = sfr.sfr_wr_i && (sfr.sfr_addr_i == ADDR_TH1);
  assign wr_tm1  = sfr.sfr_wr_i && (sfr.sfr_addr_i == ADDR_TM1);

  // Count write-back, staging of high bytes and the TL1-triggered commit
  always_comb begin
    th1_d      = tmr_th1_i;
    tm1_d      = tmr_tm1_i;
    tl1_d      = tmr_tl1_i;
    stg_th1_d  = stg_th1_q;
    stg_tm1_d  = stg_tm1_q;
    pend_th1_d = pend_th1_q;
    pend_tm1_d = pend_tm1_q;
    if (wr_tl1) begin
      th1_d      = pend_th1_q ? stg_th1_q : tmr_th1_i;
      tm1_d      = pend_tm1_q ? stg_tm1_q : tmr_tm1_i;
      tl1_d      = sfr.sfr_wdata_i;
      pend_th1_d = 1'b0;
      pend_tm1_d = 1'b0;
    end
    if (wr_th1) begin
      stg_th1_d  = sfr.sfr_wdata_i;
      pend_th1_d = 1'b1;
    end
    if (wr_tm1) begin
      stg_tm1_d  = sfr.sfr_wdata_i;
      pend_tm1_d = 1'b1;
    end
  end

  // Read mux from pre-write state; TL1 read freezes the upper bytes for TM1/TH1
  always_comb begin
    rdata_d    = 8'h00;
    rvalid_d   = sfr.sfr_rd_i;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    if (sfr.sfr_rd_i) begin
      unique case (sfr.sfr_addr_i)
        ADDR_TL1: begin
          rdata_d    = tl1_q;
          snap_d     = {th1_q, tm1_q};
          snap_vld_d = 1'b1;
        end
        ADDR_TM1: rdata_d = snap_vld_q ? snap_q[7:0] : tm1_q;
        ADDR_TH1: begin
          rdata_d    = snap_vld_q ? snap_q[15:8] : th1_q;
          snap_vld_d = 1'b0;
        end
        ADDR_TCON: rdata_d = {tf1_q, tr1_q, tcon_lo_q};
        ADDR_TMOD: rdata_d = {tmod_q, 4'h0};
        default:   rdata_d = 8'h00;
      endcase
    end
  end

  // Control bits; TF1 favours a fresh overflow over ack, ack over a CPU write
  always_comb begin
    tr1_d     = tr1_q;
    tcon_lo_d = tcon_lo_q;
    tmod_d    = tmod_q;
    if (wr_tcon) begin
      tr1_d     = sfr.sfr_wdata_i[6];
      tcon_lo_d = sfr.sfr_wdata_i[5:0];
    end
    if (wr_tmod) tmod_d = sfr.sfr_wdata_i[7:4];
    if (tmr_tf1_i && !tf1_q)  tf1_d = 1'b1;
    else if (int_ack_t1_i)    tf1_d = 1'b0;
    else if (wr_tcon)         tf1_d = sfr.sfr_wdata_i[7];
    else                      tf1_d = tmr_tf1_i;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge timers_clock_i) begin
    if (!timers_reset_i_b) begin
      th1_q      <= 8'h00;
      tm1_q      <= 8'h00;
      tl1_q      <= 8'h00;
      stg_th1_q  <= 8'h00;
      stg_tm1_q  <= 8'h00;
      pend_th1_q <= 1'b0;
      pend_tm1_q <= 1'b0;
      snap_q     <= 16'h0000;
      snap_vld_q <= 1'b0;
      tf1_q      <= 1'b0;
      tr1_q      <= 1'b0;
      tcon_lo_q  <= 6'h00;
      tmod_q     <= 4'h0;
      rdata_q    <= 8'h00;
      rvalid_q   <= 1'b0;
    end else begin
      th1_q      <= th1_d;
      tm1_q      <= tm1_d;
      tl1_q      <= tl1_d;
      stg_th1_q  <= stg_th1_d;
      stg_tm1_q  <= stg_tm1_d;
      pend_th1_q <= pend_th1_d;
      pend_tm1_q <= pend_tm1_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      tf1_q      <= tf1_d;
      tr1_q      <= tr1_d;
      tcon_lo_q  <= tcon_lo_d;
      tmod_q     <= tmod_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign sfr.sfr_rdata_o  = rdata_q;
  assign sfr.sfr_rvalid_o = rvalid_q;
  assign sfr_th1_o        = th1_q;
  assign sfr_tm1_o        = tm1_q;
  assign sfr_tl1_o        = tl1_q;
  assign sfr_tf1_o        = tf1_q;
  assign sfr_tr1_o        = tr1_q;
  assign sfr_gate_t1_o    = tmod_q[3];
  assign sfr_m1t1_o       = tmod_q[1];
  assign sfr_m0t1_o       = tmod_q[0];
  assign int_req_t1_o     = tf1_q & int_en_t1_i;

endmodule

// File: tb/tb_timers_t1_sfr_bank.sv
// tb/tb_timers_t1_sfr_bank.sv - scoreboard bench for timers_t1_sfr_bank
module tb_timers_t1_sfr_bank;
  localparam logic [7:0] A_TCON = 8'h88;
  localparam logic [7:0] A_TMOD = 8'h89;
  localparam logic [7:0] A_TL1  = 8'h8B;
  localparam logic [7:0] A_TH1  = 8'h8D;
  localparam logic [7:0] A_TM1  = 8'h8E;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstb;
  logic [7:0] th_i, tm_i, tl_i;
  logic       tf_i, en, ack;
  logic [7:0] th_o, tm_o, tl_o;
  logic       tf_o, tr_o, gate_o, m1_o, m0_o, irq;

  timers_t1_sfr_bank_if bus ();

  timers_t1_sfr_bank dut (
    .timers_clock_i   (clk),
    .timers_reset_i_b (rstb),
    .sfr              (bus),
    .tmr_th1_i        (th_i),
    .tmr_tm1_i        (tm_i),
    .tmr_tl1_i        (tl_i),
    .tmr_tf1_i        (tf_i),
    .sfr_th1_o        (th_o),
    .sfr_tm1_o        (tm_o),
    .sfr_tl1_o        (tl_o),
    .sfr_tf1_o        (tf_o),
    .sfr_tr1_o        (tr_o),
    .sfr_gate_t1_o    (gate_o),
    .sfr_m1t1_o       (m1_o),
    .sfr_m0t1_o       (m0_o),
    .int_en_t1_i      (en),
    .int_ack_t1_i     (ack),
    .int_req_t1_o     (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: 24-bit count as one number, staged bytes, snapshot, control bits
  logic [23:0] m_cnt;
  logic [7:0]  m_sh, m_sm;
  logic        m_ph, m_pm;
  logic [15:0] m_snap;
  logic        m_sv;
  logic        m_tf1, m_tr1;
  logic [5:0]  m_tlo;
  logic [3:0]  m_tmod;
  logic        g_en;

  typedef struct packed {
    logic [23:0] cnt;
    logic tf1, tr1, gate, m1, m0, irq, rvalid;
  } st_t;

  st_t        st_q[$];
  logic [7:0] rd_q[$];
  st_t        exp_st, act_st;

  // Monitor: read data popped on rvalid, visible state compared every cycle
  always @(negedge clk) begin
    if (bus.sfr_rvalid_o === 1'b1) begin
      if (rd_q.size() == 0) check("rvalid_unexpected", {31'd0, bus.sfr_rvalid_o}, 32'd0);
      else check("rdata", {24'd0, bus.sfr_rdata_o}, {24'd0, rd_q.pop_front()});
    end
    if (st_q.size() > 0) begin
      exp_st = st_q.pop_front();
      act_st = {th_o, tm_o, tl_o, tf_o, tr_o, gate_o, m1_o, m0_o, irq, bus.sfr_rvalid_o};
      if (act_st !== exp_st) $display("FAIL state: got %h expected %h", act_st, exp_st);
      n_checks++;
      if (act_st === exp_st) n_pass++;
    end
  end

  task automatic cyc(input logic rb, input logic [7:0] addr, input logic wr, input logic rd,
                     input logic [7:0] wd, input logic ak, input logic tfe, input logic [23:0] tcnt);
    logic [7:0] rv;
    logic       nt;
    @(negedge clk);
    #1;
    rstb = rb;
    bus.sfr_addr_i = addr; bus.sfr_wr_i = wr; bus.sfr_rd_i = rd; bus.sfr_wdata_i = wd;
    ack = ak; en = g_en;
    {th_i, tm_i, tl_i} = tcnt;
    tf_i = m_tf1 | tfe;
    if (!rb) begin
      m_cnt = 24'h0; m_sh = 8'h0; m_sm = 8'h0; m_ph = 1'b0; m_pm = 1'b0;
      m_snap = 16'h0; m_sv = 1'b0; m_tf1 = 1'b0; m_tr1 = 1'b0; m_tlo = 6'h0; m_tmod = 4'h0;
    end else begin
      if (rd) begin
        rv = 8'h00;
        case (addr)
          A_TL1:  begin rv = m_cnt[7:0]; m_snap = m_cnt[23:8]; m_sv = 1'b1; end
          A_TM1:  rv = m_sv ? m_snap[7:0] : m_cnt[15:8];
          A_TH1:  begin rv = m_sv ? m_snap[15:8] : m_cnt[23:16]; m_sv = 1'b0; end
          A_TCON: rv = {m_tf1, m_tr1, m_tlo};
          A_TMOD: rv = {m_tmod, 4'h0};
          default: rv = 8'h00;
        endcase
        rd_q.push_back(rv);
      end
      if (tf_i && !m_tf1)            nt = 1'b1;
      else if (ak)                   nt = 1'b0;
      else if (wr && addr == A_TCON) nt = wd[7];
      else                           nt = tf_i;
      if (wr && addr == A_TL1) begin
        m_cnt = {m_ph ? m_sh : tcnt[23:16], m_pm ? m_sm : tcnt[15:8], wd};
        m_ph = 1'b0; m_pm = 1'b0;
      end else begin
        m_cnt = tcnt;
      end
      if (wr && addr == A_TH1)  begin m_sh = wd; m_ph = 1'b1; end
      if (wr && addr == A_TM1)  begin m_sm = wd; m_pm = 1'b1; end
      if (wr && addr == A_TCON) begin m_tr1 = wd[6]; m_tlo = wd[5:0]; end
      if (wr && addr == A_TMOD) m_tmod = wd[7:4];
      m_tf1 = nt;
    end
    st_q.push_back({m_cnt, m_tf1, m_tr1, m_tmod[3], m_tmod[1], m_tmod[0],
                    m_tf1 & g_en, rb & rd});
  endtask

  task automatic idle(input logic tfe, input logic ak);
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, ak, tfe, m_cnt + 24'd1);
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b1, a, 1'b1, 1'b0, d, 1'b0, 1'b0, m_cnt + 24'd1);
  endtask

  task automatic sfr_read(input logic [7:0] a);
    cyc(1'b1, a, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, m_cnt + 24'd1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] addrs [6];

  initial begin
    rstb = 1'b0; bus.sfr_addr_i = 8'h00; bus.sfr_wr_i = 1'b0; bus.sfr_rd_i = 1'b0;
    bus.sfr_wdata_i = 8'h00; th_i = 8'h00; tm_i = 8'h00; tl_i = 8'h00;
    tf_i = 1'b0; en = 1'b0; ack = 1'b0; g_en = 1'b0;
    m_cnt = 24'h0; m_tf1 = 1'b0;
    addrs[0] = A_TCON; addrs[1] = A_TMOD; addrs[2] = A_TL1;
    addrs[3] = A_TH1;  addrs[4] = A_TM1;  addrs[5] = 8'h80;

    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0);
    repeat (3) cyc(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h123456);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 24'h123456);
    after_edge();
    check("reset_count", {8'd0, th_o, tm_o, tl_o}, 32'h0);
    check("reset_irq_rvalid", {30'd0, irq, bus.sfr_rvalid_o}, 32'd0);
    cyc(1'b1, A_TL1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 24'h123456);
    after_edge();
    check("reset_tl1_read", {24'd0, bus.sfr_rdata_o}, 32'h00);

    sfr_write(A_TH1, 8'hAB);
    sfr_write(A_TM1, 8'hCD);
    sfr_write(A_TL1, 8'hEF);
    after_edge();
    check("atomic_commit", {8'd0, th_o, tm_o, tl_o}, 32'h00ABCDEF);
    sfr_write(A_TL1, 8'h01);
    after_edge();
    check("tl1_only_commit", {8'd0, th_o, tm_o, tl_o}, 32'h00ABCD01);

    sfr_write(A_TH1, 8'h00);
    sfr_write(A_TM1, 8'hFF);
    sfr_write(A_TL1, 8'hFF);
    sfr_read(A_TL1);
    after_edge();
    check("coh_tl1", {24'd0, bus.sfr_rdata_o}, 32'hFF);
    sfr_read(A_TM1);
    after_edge();
    check("coh_tm1", {24'd0, bus.sfr_rdata_o}, 32'hFF);
    sfr_read(A_TH1);
    after_edge();
    check("coh_th1", {24'd0, bus.sfr_rdata_o}, 32'h00);

    g_en = 1'b1;
    idle(1'b1, 1'b0);
    after_edge();
    check("ovf_tf1_irq", {30'd0, tf_o, irq}, 32'd3);
    idle(1'b0, 1'b1);
    after_edge();
    check("ack_clears", {30'd0, tf_o, irq}, 32'd0);
    idle(1'b1, 1'b1);
    after_edge();
    check("set_beats_ack", {31'd0, tf_o}, 32'd1);
    idle(1'b0, 1'b1);
    cyc(1'b1, A_TCON, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, m_cnt + 24'd1);
    after_edge();
    check("tcon_with_set", {30'd0, tf_o, tr_o}, 32'd3);

    sfr_write(A_TMOD, 8'hB0);
    after_edge();
    check("tmod_bits", {29'd0, gate_o, m1_o, m0_o}, 32'd7);
    sfr_read(A_TMOD);
    after_edge();
    check("tmod_read", {24'd0, bus.sfr_rdata_o}, 32'hB0);
    sfr_read(8'h80);
    after_edge();
    check("unmapped_read", {23'd0, bus.sfr_rvalid_o, bus.sfr_rdata_o}, 32'h100);

    for (int i = 0; i < 400; i++) begin
      g_en = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 63) != 0), addrs[$urandom_range(0, 5)],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0) ? 24'($urandom) : m_cnt + 24'd1);
    end
    repeat (3) idle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rd_queue_drain", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
